// File: rtl/parser_frame_sequencer_pkg.sv
// Shared types and constants for the Ethernet/IPv4 frame sequencer.
package parser_frame_sequencer_pkg;

    localparam int unsigned SEQ_DATA_W    = 64;
    localparam int unsigned ETH_HDR_LEN   = 14;
    // Beats that carry any Ethernet header byte (ceil(hdr_bits / data_w)).
    localparam int unsigned ETH_HDR_BEATS = (ETH_HDR_LEN * 8 + SEQ_DATA_W - 1) / SEQ_DATA_W;

    typedef enum logic [1:0] {
        IPV4_OK  = 2'd0,
        NON_IPV4 = 2'd1,
        RUNT     = 2'd2,
        TIMEOUT  = 2'd3
    } frame_status_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ETH       = 3'd1,
        WAIT_TYPE = 3'd2,
        REPLAY    = 3'd3,
        IPV4      = 3'd4,
        PAYLOAD   = 3'd5,
        DROP      = 3'd6
    } seq_state_e;

endpackage

// File: rtl/parser_frame_sequencer_watchdog.sv
// Clearable saturating cycle counter; terminal count flags a missing done pulse.
module parser_frame_sequencer_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles since the last clear, holding at the terminal value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC_VAL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc_c = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/parser_frame_sequencer.sv
// Frame-level steering between the Ethernet and IPv4 header parsers:
// feeds the Ethernet parser, holds the boundary beat until EtherType is
// known, replays it to the IPv4 parser, then drains or drops the frame.
module parser_frame_sequencer
    import parser_frame_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = SEQ_DATA_W,
    parameter int unsigned ETH_BEATS   = ETH_HDR_BEATS,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              eth_tvalid,
    input  logic              eth_tready,
    input  logic              eth_done,
    input  logic              is_ipv4,
    output logic [DATA_W-1:0] ip_tdata,
    output logic              ip_tvalid,
    output logic              ip_tlast,
    input  logic              ip_tready,
    input  logic              ipv4_done,
    output logic              frame_done,
    output logic [1:0]        frame_status,
    output logic [CNT_W-1:0]  stat_ipv4_cnt,
    output logic [CNT_W-1:0]  stat_drop_cnt,
    output logic              busy
);

    localparam int unsigned BEAT_W = (ETH_BEATS > 1) ? $clog2(ETH_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_ETH_BEAT = BEAT_W'(ETH_BEATS - 1);

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [BEAT_W-1:0] r_beat;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_last;
    frame_status_e     r_drop_status;
    logic              r_frame_done;
    frame_status_e     r_frame_status;
    logic [CNT_W-1:0]  r_ipv4_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_xfer;
    logic              w_tlast_xfer;
    logic              w_timeout;
    logic              w_wd_en;
    logic              w_state_change;
    logic              w_hold_load;
    logic              w_drop_load;
    frame_status_e     w_drop_status;
    logic              w_fin;
    frame_status_e     w_fin_status;

    assign w_xfer         = s_axis_tvalid && s_axis_tready;
    assign w_tlast_xfer   = w_xfer && s_axis_tlast;
    assign w_state_change = (r_state != w_next_state);

    // Watchdog restarts on every state entry and runs only while a done pulse is awaited
    parser_frame_sequencer_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_clear (w_state_change),
        .i_en    (w_wd_en),
        .o_tc_c  (w_timeout)
    );

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus frame-termination and latch decisions; done pulses win over timeout
    always_comb begin
        w_next_state  = r_state;
        w_hold_load   = 1'b0;
        w_drop_load   = 1'b0;
        w_drop_status = NON_IPV4;
        w_fin         = 1'b0;
        w_fin_status  = IPV4_OK;
        case (r_state)
            IDLE: begin
                if (s_axis_tvalid) begin
                    w_next_state = ETH;
                end
            end
            ETH: begin
                if (w_xfer) begin
                    if (r_beat == LAST_ETH_BEAT) begin
                        w_hold_load  = 1'b1;
                        w_next_state = WAIT_TYPE;
                    end else if (s_axis_tlast) begin
                        w_fin        = 1'b1;
                        w_fin_status = RUNT;
                        w_next_state = IDLE;
                    end
                end
            end
            WAIT_TYPE: begin
                if (eth_done) begin
                    if (is_ipv4) begin
                        if (r_hold_last) begin
                            w_fin        = 1'b1;
                            w_fin_status = RUNT;
                            w_next_state = IDLE;
                        end else begin
                            w_next_state = REPLAY;
                        end
                    end else if (r_hold_last) begin
                        w_fin        = 1'b1;
                        w_fin_status = NON_IPV4;
                        w_next_state = IDLE;
                    end else begin
                        w_drop_load   = 1'b1;
                        w_drop_status = NON_IPV4;
                        w_next_state  = DROP;
                    end
                end else if (w_timeout) begin
                    if (r_hold_last) begin
                        w_fin        = 1'b1;
                        w_fin_status = TIMEOUT;
                        w_next_state = IDLE;
                    end else begin
                        w_drop_load   = 1'b1;
                        w_drop_status = TIMEOUT;
                        w_next_state  = DROP;
                    end
                end
            end
            REPLAY: begin
                if (ip_tready) begin
                    w_next_state = IPV4;
                end
            end
            IPV4: begin
                if (ipv4_done) begin
                    if (w_tlast_xfer) begin
                        w_fin        = 1'b1;
                        w_fin_status = IPV4_OK;
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = PAYLOAD;
                    end
                end else if (w_tlast_xfer) begin
                    w_fin        = 1'b1;
                    w_fin_status = RUNT;
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_drop_load   = 1'b1;
                    w_drop_status = TIMEOUT;
                    w_next_state  = DROP;
                end
            end
            PAYLOAD: begin
                if (w_tlast_xfer) begin
                    w_fin        = 1'b1;
                    w_fin_status = IPV4_OK;
                    w_next_state = IDLE;
                end
            end
            DROP: begin
                if (w_tlast_xfer) begin
                    w_fin        = 1'b1;
                    w_fin_status = r_drop_status;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Stream steering: which parser sees the beat and whose ready backs the input
    always_comb begin
        s_axis_tready = 1'b0;
        eth_tvalid    = 1'b0;
        ip_tdata      = '0;
        ip_tvalid     = 1'b0;
        ip_tlast      = 1'b0;
        w_wd_en       = 1'b0;
        case (r_state)
            ETH: begin
                eth_tvalid    = s_axis_tvalid;
                s_axis_tready = eth_tready;
            end
            WAIT_TYPE: begin
                w_wd_en = 1'b1;
            end
            REPLAY: begin
                ip_tvalid = 1'b1;
                ip_tdata  = r_hold_data;
            end
            IPV4: begin
                ip_tdata      = s_axis_tdata;
                ip_tvalid     = s_axis_tvalid;
                ip_tlast      = s_axis_tlast;
                s_axis_tready = ip_tready;
                w_wd_en       = 1'b1;
            end
            PAYLOAD, DROP: begin
                s_axis_tready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Ethernet beat counter, boundary-beat hold register and drop-status latch
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat        <= '0;
            r_hold_data   <= '0;
            r_hold_last   <= 1'b0;
            r_drop_status <= IPV4_OK;
        end else begin
            if (r_state == IDLE) begin
                r_beat <= '0;
            end else if ((r_state == ETH) && w_xfer) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (w_hold_load) begin
                r_hold_data <= s_axis_tdata;
                r_hold_last <= s_axis_tlast;
            end
            if (w_drop_load) begin
                r_drop_status <= w_drop_status;
            end
        end
    end

    // Registered per-frame status pulse and wrapping frame statistics
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_done   <= 1'b0;
            r_frame_status <= IPV4_OK;
            r_ipv4_cnt     <= '0;
            r_drop_cnt     <= '0;
        end else begin
            r_frame_done <= w_fin;
            if (w_fin) begin
                r_frame_status <= w_fin_status;
                if (w_fin_status == IPV4_OK) begin
                    r_ipv4_cnt <= r_ipv4_cnt + CNT_W'(1);
                end else begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign frame_done    = r_frame_done;
    assign frame_status  = r_frame_status;
    assign stat_ipv4_cnt = r_ipv4_cnt;
    assign stat_drop_cnt = r_drop_cnt;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_parser_frame_sequencer.sv
// Directed bench for parser_frame_sequencer with hand-computed expectations.
module tb_parser_frame_sequencer;

    localparam int ETH_B = 2;

    logic        aclk;
    logic        aresetn;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        eth_tvalid;
    logic        eth_tready;
    logic        eth_done;
    logic        is_ipv4;
    logic [63:0] ip_tdata;
    logic        ip_tvalid;
    logic        ip_tlast;
    logic        ip_tready;
    logic        ipv4_done;
    logic        frame_done;
    logic [1:0]  frame_status;
    logic [31:0] stat_ipv4_cnt;
    logic [31:0] stat_drop_cnt;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    int          xfer_q[$];
    logic [63:0] ip_q[$];
    logic [1:0]  done_st_q[$];
    int          done_edge_q[$];
    int          ip_last_cnt = 0;
    logic        ip_seen = 1'b0;

    parser_frame_sequencer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .eth_tvalid    (eth_tvalid),
        .eth_tready    (eth_tready),
        .eth_done      (eth_done),
        .is_ipv4       (is_ipv4),
        .ip_tdata      (ip_tdata),
        .ip_tvalid     (ip_tvalid),
        .ip_tlast      (ip_tlast),
        .ip_tready     (ip_tready),
        .ipv4_done     (ipv4_done),
        .frame_done    (frame_done),
        .frame_status  (frame_status),
        .stat_ipv4_cnt (stat_ipv4_cnt),
        .stat_drop_cnt (stat_drop_cnt),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Observe handshakes mid-cycle; a transfer seen here lands on edge cyc+1
    always @(negedge aclk) begin
        if (s_axis_tvalid && s_axis_tready) xfer_q.push_back(cyc + 1);
        if (ip_tvalid) ip_seen = 1'b1;
        if (ip_tvalid && ip_tready) begin
            ip_q.push_back(ip_tdata);
            if (ip_tlast) ip_last_cnt++;
        end
        if (frame_done) begin
            done_st_q.push_back(frame_status);
            done_edge_q.push_back(cyc);
        end
    end

    function automatic logic [63:0] bdat(input logic [63:0] base, input int i);
        return base + 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        xfer_q.delete();
        ip_q.delete();
        done_st_q.delete();
        done_edge_q.delete();
        ip_last_cnt = 0;
        ip_seen     = 1'b0;
    endtask

    // Source one frame; eth_done follows beat 1, ipv4_done rides the accepted beat ipv4_at
    task automatic run_frame(input int nbeats, input logic [63:0] base, input logic v4,
                             input logic give_eth, input int ipv4_at, input logic tog,
                             input int stop_at);
        int   sent      = 0;
        int   k         = 0;
        logic eth_fired = 1'b0;
        logic ip_fired  = 1'b0;
        while (sent < stop_at && k < 300) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bdat(base, sent);
            s_axis_tlast  = (sent == nbeats - 1);
            ip_tready     = tog ? ~ip_tready : 1'b1;
            eth_done      = 1'b0;
            is_ipv4       = 1'b0;
            ipv4_done     = 1'b0;
            if (give_eth && !eth_fired && sent == ETH_B) begin
                eth_done  = 1'b1;
                is_ipv4   = v4;
                eth_fired = 1'b1;
            end
            if (!ip_fired && sent == ipv4_at && ip_tready) begin
                ipv4_done = 1'b1;
                ip_fired  = 1'b1;
            end
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) sent++;
            @(posedge aclk);
            #1;
            k++;
        end
        eth_done  = 1'b0;
        is_ipv4   = 1'b0;
        ipv4_done = 1'b0;
        chk("frame_budget", 64'(sent), 64'(stop_at));
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        ip_tready     = 1'b1;
        while (done_st_q.size() < n && k < 200) begin
            @(posedge aclk);
            #1;
            k++;
        end
        chk("done_count", 64'(done_st_q.size()), 64'(n));
    endtask

    localparam logic [63:0] B_V4  = 64'h1111_2222_0000_0000;
    localparam logic [63:0] B_ARP = 64'h0806_0806_0000_0000;
    localparam logic [63:0] B_RNT = 64'h5555_0000_0000_0000;
    localparam logic [63:0] B_TO  = 64'h7777_0000_0000_0000;
    localparam logic [63:0] B_A   = 64'hAAAA_0000_0000_0000;
    localparam logic [63:0] B_B   = 64'hBBBB_0000_0000_0000;
    localparam logic [63:0] B_R   = 64'hCCCC_0000_0000_0000;

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        eth_tready    = 1'b1;
        eth_done      = 1'b0;
        is_ipv4       = 1'b0;
        ip_tready     = 1'b1;
        ipv4_done     = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_done",   64'(frame_done), 64'd0);
        chk("rst_ipcnt",  64'(stat_ipv4_cnt), 64'd0);
        chk("rst_dropcnt", 64'(stat_drop_cnt), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // IPv4 frame: replay of beat 1, then beats 2..4 to the IPv4 parser
        clear_mon();
        run_frame(8, B_V4, 1'b1, 1'b1, 4, 1'b0, 8);
        wait_done(1);
        chk("v4_status",  64'(done_st_q[0]), 64'd0);
        chk("v4_done_at_tlast", 64'(done_edge_q[0]), 64'(xfer_q[7]));
        chk("v4_ip_len",  64'(ip_q.size()), 64'd4);
        chk("v4_ip0_replay", ip_q[0], bdat(B_V4, 1));
        chk("v4_ip1",     ip_q[1], bdat(B_V4, 2));
        chk("v4_ip2",     ip_q[2], bdat(B_V4, 3));
        chk("v4_ip3",     ip_q[3], bdat(B_V4, 4));
        chk("v4_ip_last", 64'(ip_last_cnt), 64'd0);
        chk("v4_ipcnt",   64'(stat_ipv4_cnt), 64'd1);
        chk("v4_dropcnt", 64'(stat_drop_cnt), 64'd0);
        chk("v4_idle",    64'(busy), 64'd0);

        // ARP frame: dropped after classification, IPv4 side stays silent
        clear_mon();
        run_frame(8, B_ARP, 1'b0, 1'b1, -1, 1'b0, 8);
        wait_done(1);
        chk("arp_status", 64'(done_st_q[0]), 64'd1);
        chk("arp_ipvalid", 64'(ip_seen), 64'd0);
        chk("arp_xfers",  64'(xfer_q.size()), 64'd8);
        chk("arp_dropcnt", 64'(stat_drop_cnt), 64'd1);
        chk("arp_ipcnt",  64'(stat_ipv4_cnt), 64'd1);

        // Single-beat runt: reported on the edge after its only beat
        clear_mon();
        run_frame(1, B_RNT, 1'b1, 1'b1, -1, 1'b0, 1);
        wait_done(1);
        chk("runt_status", 64'(done_st_q[0]), 64'd2);
        chk("runt_timing", 64'(done_edge_q[0]), 64'(xfer_q[0]));
        chk("runt_dropcnt", 64'(stat_drop_cnt), 64'd2);

        // eth_done withheld: 64 cycles in WAIT_TYPE, then the frame is drained
        clear_mon();
        run_frame(8, B_TO, 1'b1, 1'b0, -1, 1'b0, 8);
        wait_done(1);
        chk("to_status", 64'(done_st_q[0]), 64'd3);
        chk("to_wait",   64'(xfer_q[2] - xfer_q[1]), 64'd65);
        chk("to_drain",  64'(done_edge_q[0]), 64'(xfer_q[7]));
        chk("to_ipvalid", 64'(ip_seen), 64'd0);
        chk("to_dropcnt", 64'(stat_drop_cnt), 64'd3);

        // Back-to-back IPv4 frames with ip_tready toggling every cycle
        clear_mon();
        ip_tready = 1'b0;
        run_frame(8, B_A, 1'b1, 1'b1, 4, 1'b1, 8);
        run_frame(8, B_B, 1'b1, 1'b1, 4, 1'b1, 8);
        wait_done(2);
        chk("b2b_status0", 64'(done_st_q[0]), 64'd0);
        chk("b2b_status1", 64'(done_st_q[1]), 64'd0);
        chk("b2b_xfers",  64'(xfer_q.size()), 64'd16);
        chk("b2b_ip_len", 64'(ip_q.size()), 64'd8);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ipA", ip_q[i], bdat(B_A, i + 1));
            chk("b2b_ipB", ip_q[i + 4], bdat(B_B, i + 1));
        end
        chk("b2b_ipcnt", 64'(stat_ipv4_cnt), 64'd3);

        // Reset while in IPV4: everything clears at once, next frame is clean
        clear_mon();
        run_frame(8, B_R, 1'b1, 1'b1, -1, 1'b0, 3);
        chk("pre_rst_busy",  64'(busy), 64'd1);
        chk("pre_rst_ipv",   64'(ip_tvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy), 64'd0);
        chk("mid_rst_ipv",   64'(ip_tvalid), 64'd0);
        chk("mid_rst_ipd",   ip_tdata, 64'd0);
        chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        chk("mid_rst_ethv",  64'(eth_tvalid), 64'd0);
        chk("mid_rst_ipcnt", 64'(stat_ipv4_cnt), 64'd0);
        chk("mid_rst_dropcnt", 64'(stat_drop_cnt), 64'd0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        clear_mon();
        run_frame(8, B_V4, 1'b1, 1'b1, 4, 1'b0, 8);
        wait_done(1);
        chk("post_rst_status", 64'(done_st_q[0]), 64'd0);
        chk("post_rst_ip0", ip_q[0], bdat(B_V4, 1));
        chk("post_rst_ipcnt", 64'(stat_ipv4_cnt), 64'd1);
        chk("post_rst_dropcnt", 64'(stat_drop_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/parser_frame_sequencer.md
Name: parser_frame_sequencer

Overview:
- Frame-level controller in front of the Ethernet and IPv4 header parsers.
- Steers each input AXIS beat to the correct parser and gates the IPv4 parser until the Ethernet parser has classified the EtherType.
- Replays the boundary beat (bytes 8-15, carrying both EtherType and the first IPv4 bytes) to the IPv4 parser, then drains payload or drops the frame.
- Reports one status per frame and keeps frame statistics.

Parameters:
- DATA_W, 64, stream data width in bits; the block supports only 64.
- ETH_BEATS, 2, beats that carry Ethernet header bytes. Equals ceil(eth_hdr_len*8/DATA_W).
- TIMEOUT_CYC, 64, maximum cycles to wait for eth_done or ipv4_done.
- CNT_W, 32, statistics counter width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_W  input frame data
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input last beat
- s_axis_tready  out  1  input ready
- eth_tvalid  out  1  valid toward Ethernet parser (data = s_axis_tdata)
- eth_tready  in  1  Ethernet parser ready
- eth_done  in  1  Ethernet header parsed (1-cycle pulse)
- is_ipv4  in  1  EtherType 0x0800, qualified by eth_done
- ip_tdata  out  DATA_W  data toward IPv4 parser
- ip_tvalid  out  1  valid toward IPv4 parser
- ip_tlast  out  1  last toward IPv4 parser
- ip_tready  in  1  IPv4 parser ready
- ipv4_done  in  1  IPv4 header parsed (1-cycle pulse)
- frame_done  out  1  1-cycle pulse at end of frame handling
- frame_status  out  2  status, valid with frame_done: 0 IPV4_OK, 1 NON_IPV4, 2 RUNT, 3 TIMEOUT
- stat_ipv4_cnt  out  CNT_W  count of IPV4_OK frames
- stat_drop_cnt  out  CNT_W  count of all other frames
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, aresetn=0):
  - State goes to IDLE.
  - All outputs are 0, including counters, hold register, beat counter and watchdog.
  - Reset mid-frame abandons the frame with no frame_done; the rest of that frame is then treated as a new frame.
- Handshake is AXIS standard: a beat transfers when valid && ready. Outputs never depend combinationally on their own ready, except s_axis_tready, which is the selected parser ready.
- IDLE:
  - s_axis_tready=0.
  - When s_axis_tvalid=1, go to ETH in the next cycle with beat counter = 0.
- ETH:
  - eth_tvalid = s_axis_tvalid; s_axis_tready = eth_tready.
  - On each transfer the beat counter increments.
  - Transfer of beat ETH_BEATS-1: capture tdata and tlast into the hold register, go to WAIT_TYPE.
  - Transfer with tlast on an earlier beat: pulse frame_done with RUNT, go to IDLE.
- WAIT_TYPE:
  - s_axis_tready=0; the watchdog counts.
  - eth_done && is_ipv4 && !hold_last: go to REPLAY.
  - eth_done && is_ipv4 && hold_last: RUNT, go to IDLE.
  - eth_done && !is_ipv4: go to DROP, or end with NON_IPV4 directly to IDLE if hold_last.
  - Watchdog reaching TIMEOUT_CYC: TIMEOUT, go to DROP (or IDLE if hold_last).
- REPLAY:
  - ip_tvalid=1, ip_tdata=hold, ip_tlast=0; s_axis_tready=0.
  - On ip_tready, go to IPV4.
- IPV4:
  - ip_tdata/ip_tvalid/ip_tlast mirror s_axis; s_axis_tready = ip_tready; the watchdog counts.
  - ipv4_done: go to PAYLOAD. If ipv4_done coincides with a tlast transfer, pulse IPV4_OK and go to IDLE.
  - tlast transfer without ipv4_done: RUNT, go to IDLE.
  - Watchdog timeout: TIMEOUT, go to DROP.
- PAYLOAD:
  - s_axis_tready=1; no parser sees data.
  - On tlast transfer: IPV4_OK, go to IDLE.
- DROP:
  - s_axis_tready=1.
  - On tlast transfer: pulse frame_done with the status latched on entry, go to IDLE.
- Watchdog:
  - Clears on every state entry.
  - Timeout is asserted when the count equals TIMEOUT_CYC-1 in WAIT_TYPE or IPV4.
  - Timeout does not fire on a cycle where the corresponding done pulse arrives; done wins.
- Counters:
  - Increment in the same cycle as frame_done: ipv4 for status 0, drop otherwise.
  - Wrap at 2^CNT_W.
- frame_done and frame_status are registered: they appear one cycle after the terminating event.
- eth_done or ipv4_done arriving in any state other than the one waiting for it is ignored.

Decomposition:
- parser_pkg additions:
  - frame_status_e (IPV4_OK, NON_IPV4, RUNT, TIMEOUT).
  - seq_state_e (IDLE, ETH, WAIT_TYPE, REPLAY, IPV4, PAYLOAD, DROP).
  - ETH_BEATS localparam derived from eth_hdr_len.
- One natural sub-module: hdr_done_watchdog, a clearable counter with terminal-count output parameterised by TIMEOUT_CYC.

Test Plan:
- 64-byte IPv4 frame (8 beats, EtherType 0x0800), parsers always ready, eth_done after beat 1, ipv4_done after beat 4:
  - ip_tdata first equals beat 1 (replay), then beats 2..4.
  - frame_done with status 0; stat_ipv4_cnt=1.
- ARP frame (EtherType 0x0806, 8 beats), eth_done with is_ipv4=0:
  - ip_tvalid never asserted; remaining 6 beats drained.
  - status 1; stat_drop_cnt=1.
- Single-beat frame (tlast on beat 0): status 2 after one cycle; eth_done is never waited on.
- eth_done withheld: after exactly 64 cycles in WAIT_TYPE, status 3; the frame is drained to tlast.
- Two back-to-back IPv4 frames with ip_tready toggling 1/0 each cycle: no beat lost or duplicated; both report status 0; stat_ipv4_cnt=2.
- aresetn pulsed low in IPV4 state: all outputs are 0 immediately; after release, the next valid frame completes with status 0.
